fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream_if.sv | 27 ++
 rtl/fifo_rd_stream.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream_if
//  Description : Valid/ready output stream carried by the FIFO read stage.
//                master = producer (drives valid/data), slave = consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             dout_valid;
    logic             dout_ready;
    logic [DSIZE-1:0] dout_data;

    modport master (
        output dout_valid,
        output dout_data,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_data,
        output dout_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side output stage of the async FIFO. Issues rinc from
//                rempty under credit control, captures the one-cycle-latency
//                RAM data into a 2-entry buffer and presents it as a
//                valid/ready stream without loss or duplication.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DSIZE = 8
) (
    input  wire logic             rclk,
    input  wire logic             rrst,
    input  wire logic             rempty,
    output logic                  rinc,
    input  wire logic [DSIZE-1:0] rdata,
    fifo_rd_stream_if.master      dout,
    output logic [1:0]            ob_level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state_q,    w_state_d;
    logic             r_inflight_q, w_inflight_d;
    logic [DSIZE-1:0] r_slot0_q,    w_slot0_d;
    logic [DSIZE-1:0] r_slot1_q,    w_slot1_d;

    logic             w_pop;
    logic             w_wr;
    logic [2:0]       w_credit;

    // Stream outputs come straight from the head slot and the state encoding
    assign ob_level        = logic'(1'b0) ? 2'd0 : r_state_q;
    assign dout.dout_valid = (r_state_q != ST_EMPTY);
    assign dout.dout_data  = r_slot0_q;

    assign w_pop = (r_state_q != ST_EMPTY) && dout.dout_ready;
    assign w_wr  = r_inflight_q;

    // Credit rule: words held + word in flight - word leaving, kept at 3 bits
    // so the subtraction never wraps; a read is issued only if it will fit.
    always_comb begin
        w_credit = {1'b0, r_state_q} + {2'b00, r_inflight_q} - {2'b00, w_pop};
        rinc     = !rrst && !rempty && (w_credit < 3'd2);
    end

    // Buffer next-state: shift on pop, write RAM data into the tail position
    always_comb begin
        w_state_d    = r_state_q;
        w_slot0_d    = r_slot0_q;
        w_slot1_d    = r_slot1_q;
        w_inflight_d = rinc;
        case (r_state_q)
            ST_EMPTY: begin
                if (w_wr) begin
                    w_state_d = ST_ONE;
                    w_slot0_d = rdata;
                end
            end
            ST_ONE: begin
                if (w_wr && w_pop) begin
                    w_slot0_d = rdata;
                end else if (w_wr) begin
                    w_state_d = ST_TWO;
                    w_slot1_d = rdata;
                end else if (w_pop) begin
                    w_state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_slot0_d = r_slot1_q;
                    if (w_wr) begin
                        w_slot1_d = rdata;
                    end else begin
                        w_state_d = ST_ONE;
                    end
                end
            end
            default: begin
                w_state_d = ST_EMPTY;
            end
        endcase
    end

    // State register; reset discards buffered and in-flight words
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state_q    <= ST_EMPTY;
            r_inflight_q <= 1'b0;
            r_slot0_q    <= '0;
            r_slot1_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_inflight_q <= w_inflight_d;
            r_slot0_q    <= w_slot0_d;
            r_slot1_q    <= w_slot1_d;
        end
    end

`ifndef SYNTHESIS
    // A write into a full buffer with no pop would overflow; credits forbid it
    a_no_overflow : assert property (@(posedge rclk) disable iff (rrst)
        !((r_state_q == ST_TWO) && r_inflight_q && !w_pop));
`endif

endmodule
`default_nettype wire
